// File: rtl/cpu_mem_responder.sv
// Unified instruction/data RAM responder for CPU benches and on-chip use.
// Clears storage after reset, then serves fetches, loads and stores with one-cycle latency.
module cpu_mem_responder #(
  parameter int          ADDR_W     = 10,
  parameter bit          INIT_CLEAR = 1'b1,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_read,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_out,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        init_done,
  output logic        misalign_err
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clear_ptr;
  logic [31:0]       mem [DEPTH];
  logic              clear_en, serve;
  logic [ADDR_W-1:0] i_idx, d_idx;
  logic              fwd, misalign_req;
  logic              unused_hi;

  assign i_idx = instr_addr[ADDR_W+1:2];
  assign d_idx = data_addr[ADDR_W+1:2];
  assign fwd   = data_write && (i_idx == d_idx);
  assign misalign_req = (instr_read && (instr_addr[1:0] != 2'b00)) ||
                        ((data_read || data_write) && (data_addr[1:0] != 2'b00));
  // Upper address bits only wrap the access, they never select anything.
  assign unused_hi = ^{instr_addr[31:ADDR_W+2], data_addr[31:ADDR_W+2]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= CLEAR;
      clear_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (clear_en) clear_ptr <= clear_ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR: if (!INIT_CLEAR || (clear_ptr == {ADDR_W{1'b1}})) state_nxt = READY;
      READY: state_nxt = READY;
    endcase
  end

  always_comb begin
    init_done = 1'b0;
    clear_en  = 1'b0;
    serve     = 1'b0;
    case (state)
      CLEAR: clear_en = INIT_CLEAR;
      READY: begin
        init_done = 1'b1;
        serve     = 1'b1;
      end
    endcase
  end

  // No reset on the array itself; a store coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (clear_en)                mem[clear_ptr] <= '0;
      else if (serve && data_write) mem[d_idx]    <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_out    <= NOP_WORD;
      data_out     <= '0;
      misalign_err <= 1'b0;
    end else if (serve) begin
      if (instr_read)   instr_out    <= fwd ? data_in : mem[i_idx];
      if (data_read)    data_out     <= data_write ? data_in : mem[d_idx];
      if (misalign_req) misalign_err <= 1'b1;
    end
  end
endmodule
